// File: rtl/seq_det_stream_arbiter.sv
// Round-robin arbiter sharing one serial "in/out/reset" sequence detector among NREQ frame producers.
// Optional SEQ_ARB_ABORT_EN: a granted requester dropping req during the shift aborts its frame without done.
module seq_det_stream_arbiter #(
    parameter int NREQ = 4,
    parameter int DW   = 8,
    parameter int CW   = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic [NREQ-1:0]      grant,
    output logic                 done,
    output logic [CW-1:0]        hit_count,
    output logic                 busy,
    output logic                 det_clr,
    output logic                 det_bit,
    output logic                 det_valid,
    input  logic                 det_hit
);
    localparam int IW = $clog2(NREQ);
    localparam int BW = $clog2(DW);
    localparam logic [CW-1:0] CMAX = {CW{1'b1}};

    typedef enum logic [1:0] {IDLE, CLEAR, SHIFT, REPORT} state_t;
    state_t state, state_nxt;

    logic [IW-1:0]   last;
    logic [IW-1:0]   pick_idx;
    logic [IW-1:0]   cand;
    logic            pick_vld;
    logic [NREQ-1:0] grant_q;
    logic [DW-1:0]   sreg;
    logic [BW-1:0]   bit_cnt;
    logic [CW-1:0]   hits;
    logic [CW-1:0]   hits_nxt;
    logic            aborting;
    logic            abort_req;

    // Search starts one past the last winner so a requester that keeps req high yields to others.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IW'((int'(last) + k) % NREQ);
            if (!pick_vld && req[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
    end

`ifdef SEQ_ARB_ABORT_EN
    assign abort_req = (state == SHIFT) && !(|(req & grant_q));
`else
    assign abort_req = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        hits_nxt  = hits;
        if (det_valid && det_hit && (hits != CMAX))
            hits_nxt = hits + CW'(1);
        case (state)
            IDLE:    if (pick_vld) state_nxt = CLEAR;
            CLEAR:   state_nxt = aborting ? IDLE : SHIFT;
            SHIFT: begin
                if (abort_req)
                    state_nxt = CLEAR;
                else if (bit_cnt == BW'(DW - 1))
                    state_nxt = REPORT;
            end
            REPORT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            grant_q   <= '0;
            last      <= IW'(NREQ - 1);
            sreg      <= '0;
            bit_cnt   <= '0;
            hits      <= '0;
            hit_count <= '0;
            aborting  <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        grant_q <= NREQ'(1) << pick_idx;
                        sreg    <= req_data[pick_idx*DW +: DW];
                        last    <= pick_idx;
                    end
                end
                CLEAR: begin
                    hits     <= '0;
                    bit_cnt  <= '0;
                    aborting <= 1'b0;
                end
                SHIFT: begin
                    sreg    <= {sreg[DW-2:0], 1'b0};
                    bit_cnt <= bit_cnt + BW'(1);
                    hits    <= hits_nxt;
                    // The abort path reuses CLEAR with grant already dropped, then falls back to IDLE.
                    if (abort_req) begin
                        grant_q  <= '0;
                        aborting <= 1'b1;
                    end else if (state_nxt == REPORT) begin
                        hit_count <= hits_nxt;
                    end
                end
                REPORT:  grant_q <= '0;
                default: ;
            endcase
        end
    end

    assign grant     = grant_q;
    assign done      = (state == REPORT);
    assign busy      = (state != IDLE);
    assign det_clr   = (state == CLEAR);
    assign det_valid = (state == SHIFT);
    assign det_bit   = det_valid & sreg[DW-1];
endmodule

// File: tb/tb_seq_det_stream_arbiter.sv
// Bench for seq_det_stream_arbiter: frame-level reference model plus directed scenarios with hand-computed values.
module tb_seq_det_stream_arbiter;
    localparam int NREQ = 4;
    localparam int DW   = 8;
`ifdef SEQ_ARB_ABORT_EN
    localparam bit ABORT = 1'b1;
`else
    localparam bit ABORT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  grant, grant_s;
    logic        done, done_s, busy, busy_s;
    logic [3:0]  hit_count;
    logic [2:0]  hit_s;
    logic        det_clr, det_bit, det_valid, det_hit;
    logic        clr_s, bit_s, valid_s;

    int errors = 0;
    int checks = 0;
    int mode   = 0;   // 0: "101" detector, 1: hit always, 2: hit only when det_valid=0

    always #5 clk = ~clk;

    seq_det_stream_arbiter #(.NREQ(NREQ), .DW(DW), .CW(4)) dut (
        .clk(clk), .reset(reset), .req(req), .req_data(req_data),
        .grant(grant), .done(done), .hit_count(hit_count), .busy(busy),
        .det_clr(det_clr), .det_bit(det_bit), .det_valid(det_valid), .det_hit(det_hit)
    );

    seq_det_stream_arbiter #(.NREQ(NREQ), .DW(DW), .CW(3)) u_sat (
        .clk(clk), .reset(reset), .req(req), .req_data(req_data),
        .grant(grant_s), .done(done_s), .hit_count(hit_s), .busy(busy_s),
        .det_clr(clr_s), .det_bit(bit_s), .det_valid(valid_s), .det_hit(1'b1)
    );

    // Overlapping "101" Mealy detector attached to the main instance
    logic [1:0] dstate;
    always @(posedge clk or posedge reset) begin
        if (reset)          dstate <= 2'd0;
        else if (det_clr)   dstate <= 2'd0;
        else if (det_valid) dstate <= det_bit ? 2'd1 : ((dstate == 2'd1) ? 2'd2 : 2'd0);
    end
    assign det_hit = (mode == 0) ? (det_valid && dstate == 2'd2 && det_bit) :
                     (mode == 1) ? 1'b1 : !det_valid;

    function automatic int exp_hits(logic [7:0] f, int md, int cw);
        int n;
        int mx;
        n  = 0;
        mx = (1 << cw) - 1;
        if (md == 0) begin
            for (int i = 0; i <= DW - 3; i++)
                if (f[i +: 3] == 3'b101) n++;
        end else if (md == 1) begin
            n = DW;
        end
        return (n > mx) ? mx : n;
    endfunction

    // Frame-level model: m_k is the cycle offset since grant (0 clear, 1..DW bits, DW+1 report)
    logic       m_act, m_abort;
    int         m_k, m_idx, m_last, m_mode;
    logic [7:0] m_frame;
    logic [3:0] m_hc;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_act = 0; m_abort = 0; m_k = 0; m_idx = 0; m_last = NREQ - 1; m_hc = 0; m_mode = 0;
        end else if (!m_act) begin
            if (req != 4'b0) begin
                logic found;
                found = 0;
                for (int s = 1; s <= NREQ; s++) begin
                    if (!found && req[(m_last + s) % NREQ]) begin
                        found = 1;
                        m_idx = (m_last + s) % NREQ;
                    end
                end
                m_frame = req_data[m_idx*8 +: 8];
                m_last  = m_idx;
                m_mode  = mode;
                m_act   = 1;
                m_k     = 0;
            end
        end else if (m_abort) begin
            m_act = 0; m_abort = 0;
        end else if (ABORT && m_k >= 1 && m_k <= DW && !req[m_idx]) begin
            m_abort = 1;
        end else begin
            m_k++;
            if (m_k == DW + 1) m_hc = 4'(exp_hits(m_frame, m_mode, 4));
            if (m_k == DW + 2) m_act = 0;
        end
    end

    logic [3:0] e_grant;
    logic       e_done, e_busy, e_clr, e_valid, e_bit;
    int         cyc = 0, n_done = 0, g_cyc = 0, last_lat = 0, nval = 0, frame_vals = 0;
    logic [3:0] prev_grant = 4'b0;
    logic [3:0] glog[$];

    always @(negedge clk) begin
        cyc++;
        e_grant = (m_act && !m_abort) ? (4'b1 << m_idx) : 4'b0;
        e_clr   = m_act && (m_abort || m_k == 0);
        e_valid = m_act && !m_abort && m_k >= 1 && m_k <= DW;
        e_bit   = e_valid ? m_frame[DW - m_k] : 1'b0;
        e_done  = m_act && !m_abort && m_k == DW + 1;
        e_busy  = m_act;
        checks++;
        if ({grant, done, hit_count, busy, det_clr, det_valid, det_bit} !==
            {e_grant, e_done, m_hc, e_busy, e_clr, e_valid, e_bit}) begin
            errors++;
            $display("FAIL cycle_compare cyc=%0d got grant=%b done=%b hc=%0d busy=%b clr=%b vld=%b bit=%b exp grant=%b done=%b hc=%0d busy=%b clr=%b vld=%b bit=%b",
                     cyc, grant, done, hit_count, busy, det_clr, det_valid, det_bit,
                     e_grant, e_done, m_hc, e_busy, e_clr, e_valid, e_bit);
        end
        checks++;
        if ({grant_s, done_s, busy_s, clr_s, valid_s, bit_s} !== {e_grant, e_done, e_busy, e_clr, e_valid, e_bit}) begin
            errors++;
            $display("FAIL sat_compare cyc=%0d got grant=%b done=%b busy=%b clr=%b vld=%b bit=%b exp grant=%b done=%b busy=%b clr=%b vld=%b bit=%b",
                     cyc, grant_s, done_s, busy_s, clr_s, valid_s, bit_s, e_grant, e_done, e_busy, e_clr, e_valid, e_bit);
        end
        if (done_s) begin
            checks++;
            if (hit_s !== 3'd7) begin
                errors++;
                $display("FAIL sat_hit_count got=%0d exp=7", hit_s);
            end
        end
        if (grant != 4'b0 && prev_grant == 4'b0) begin
            glog.push_back(grant);
            g_cyc = cyc;
            nval  = 0;
        end
        if (det_valid) nval++;
        if (done) begin
            n_done++;
            last_lat   = cyc - g_cyc;
            frame_vals = nval;
        end
        prev_grant = grant;
    end

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns in the middle of the REPORT cycle, after the negedge bookkeeping has run
    task automatic wait_done(input string nm);
        logic seen;
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            if (done) seen = 1;
        end
        if (!seen) chk({nm, "_timeout"}, 0, 1);
        @(negedge clk);
        #1;
    endtask

    task automatic wait_valids(input int n);
        int c;
        c = 0;
        for (int i = 0; i < 40 && c < n; i++) begin
            tick();
            if (det_valid) c++;
        end
        if (c < n) chk("valid_timeout", c, n);
    endtask

    int dn;

    initial begin
        reset = 1; req = 4'b0; req_data = 32'h0; mode = 0;
        repeat (3) tick();
        chk("reset_grant", grant, 0);
        chk("reset_busy", busy, 0);
        chk("reset_hit_count", hit_count, 0);
        reset = 0;
        tick();

        // Single requester, 10101010 -> 3 hits, then re-granted with 11011011 -> 2 hits
        req_data[7:0] = 8'hAA; req = 4'b0001;
        wait_done("t1a");
        chk("t1_hits", hit_count, 3);
        chk("t1_latency", last_lat, DW + 1);   // grant cycle is cycle 1, done lands on cycle DW+2
        chk("t1_valid_cycles", frame_vals, 8);
        req_data[7:0] = 8'hDB;
        repeat (4) tick();
        req_data[7:0] = 8'h00;                  // mid-frame change must be ignored
        wait_done("t1b");
        chk("t1b_hits", hit_count, 2);
        chk("t1_grants", glog.size(), 2);
        if (glog.size() == 2) chk("t1_regrant", glog[1], 4'b0001);
        tick();
        req = 4'b0;
        tick();

        // Round robin from reset with req=1010 held
        reset = 1; tick(); reset = 0;
        glog.delete();
        req_data = {8'h0F, 8'h00, 8'h5A, 8'h00};
        req = 4'b1010;
        for (int f = 0; f < 3; f++) wait_done("t2");
        tick();
        req = 4'b0;
        chk("t2_grants", glog.size(), 3);
        if (glog.size() == 3) begin
            chk("t2_g0", glog[0], 4'b0010);
            chk("t2_g1", glog[1], 4'b1000);
            chk("t2_g2", glog[2], 4'b0010);
        end
        tick();

        // Detector always hitting: 8 hits on CW=4, saturated 7 on the CW=3 instance
        mode = 1; req_data[7:0] = 8'hFF; req = 4'b0001;
        wait_done("t3");
        chk("t3_hits", hit_count, 8);
        chk("t3_sat_hits", hit_s, 7);
        tick();
        req = 4'b0; mode = 0;
        tick();

        // Reset during shift bit 4, then a clean full frame for requester 2 (10110101 -> 3)
        req_data[23:16] = 8'hB5; req = 4'b0100;
        wait_valids(5);
        dn = n_done;
        reset = 1;
        tick();
        chk("t4_rst_grant", grant, 0);
        chk("t4_rst_busy", busy, 0);
        chk("t4_rst_valid", det_valid, 0);
        chk("t4_rst_hc", hit_count, 0);
        reset = 0;
        wait_done("t4");
        chk("t4_one_done", n_done - dn, 1);
        chk("t4_grant", glog[glog.size() - 1], 4'b0100);
        chk("t4_valid_cycles", frame_vals, 8);
        chk("t4_hits", hit_count, 3);
        tick();
        req = 4'b0;
        tick();

        // Granted requester drops req during shift, frame 10100101 (2 hits if completed)
        req_data[7:0] = 8'hA5; req = 4'b0001;
        wait_valids(3);
        req = 4'b0;
        dn = n_done;
        repeat (DW + 4) tick();
        chk("t5_done_count", n_done - dn, ABORT ? 0 : 1);
        chk("t5_hits", hit_count, ABORT ? 3 : 2);

        // Hits asserted only outside the shift window -> 0 for frame 00
        mode = 2; req_data[15:8] = 8'h00; req = 4'b0010;
        wait_done("t6");
        chk("t6_hits", hit_count, 0);
        tick();
        req = 4'b0; mode = 0;
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
